// File: rtl/tjmono_readout_emu.sv
// Chip-side emulator of the TJ-Monopix matrix readout port: queues hits, raises TOKEN,
// and shifts one 27-bit word out on OUT (MSB first) per accepted READ edge.
module tjmono_readout_emu #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 HIT_WR,
  input  logic [5:0]           HIT_COL,
  input  logic [8:0]           HIT_ROW,
  input  logic [5:0]           HIT_LE,
  input  logic [5:0]           HIT_TE,
  output logic                 FULL,
  output logic [ADDR_BITS:0]   HIT_COUNT,
  input  logic                 FREEZE,
  input  logic                 READ,
  output logic                 TOKEN,
  output logic                 OUT,
  output logic                 BUSY,
  output logic [7:0]           LOST_CNT,
  output logic [7:0]           READ_ERR_CNT
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   ONE_CNT  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ONE_PTR  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [26:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count, count_next;
  logic [ADDR_BITS:0]   frz_cnt, frz_eff, frz_next;
  logic                 frz, read_d, token;
  logic [7:0]           lost_cnt, err_cnt;
  state_t               state, state_next;
  logic [4:0]           bit_cnt, bit_cnt_next;
  logic [26:0]          sreg, sreg_next;
  logic                 rd_edge, wr_ok, can_load, readable, pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // On the edge FREEZE rises, the snapshot is the pre-edge count, so a same-cycle write is excluded.
  always_comb begin
    rd_edge    = READ & ~read_d;
    wr_ok      = HIT_WR & (count != FULL_CNT);
    frz_eff    = (FREEZE && !frz) ? count : frz_cnt;
    readable   = FREEZE ? (|frz_eff) : (|count);
    can_load   = (state == IDLE) || (bit_cnt == 5'd0);
    pop        = rd_edge & can_load & readable;
    count_next = count;
    if (wr_ok && !pop)
      count_next = count + ONE_CNT;
    else if (pop && !wr_ok)
      count_next = count - ONE_CNT;
    frz_next = '0;
    if (FREEZE)
      frz_next = pop ? (frz_eff - ONE_CNT) : frz_eff;
  end

  // Loading at bit 0 lets the next word follow with no idle gap.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    sreg_next    = sreg;
    if (pop) begin
      state_next   = SHIFT;
      bit_cnt_next = 5'd26;
      sreg_next    = mem[rd_ptr];
    end else if (state == SHIFT) begin
      if (bit_cnt == 5'd0) begin
        state_next = IDLE;
      end else begin
        bit_cnt_next = bit_cnt - 5'd1;
        sreg_next    = {sreg[25:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= 5'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      frz_cnt  <= '0;
      frz      <= 1'b0;
      read_d   <= 1'b0;
      token    <= 1'b0;
      lost_cnt <= 8'd0;
      err_cnt  <= 8'd0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      if (wr_ok)
        wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)
        rd_ptr <= rd_ptr + ONE_PTR;
      count   <= count_next;
      frz_cnt <= frz_next;
      frz     <= FREEZE;
      read_d  <= READ;
      token   <= FREEZE ? (|frz_next) : (|count_next);
      if (HIT_WR && !wr_ok)
        lost_cnt <= sat_inc(lost_cnt);
      if (rd_edge && !pop)
        err_cnt <= sat_inc(err_cnt);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wr_ptr] <= {HIT_COL, HIT_ROW, HIT_LE, HIT_TE};
    sreg <= sreg_next;
  end

  assign BUSY         = (state == SHIFT);
  assign OUT          = BUSY & sreg[26];
  assign FULL         = (count == FULL_CNT);
  assign HIT_COUNT    = count;
  assign TOKEN        = token;
  assign LOST_CNT     = lost_cnt;
  assign READ_ERR_CNT = err_cnt;

endmodule

// File: tb/tb_tjmono_readout_emu.sv
// Directed bench for tjmono_readout_emu: stimulus pushes expected words into a queue,
// a monitor deserialises OUT while BUSY and compares against the queue head.
module tb_tjmono_readout_emu;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       HIT_WR = 1'b0;
  logic [5:0] HIT_COL = '0;
  logic [8:0] HIT_ROW = '0;
  logic [5:0] HIT_LE = '0;
  logic [5:0] HIT_TE = '0;
  logic       FULL;
  logic [4:0] HIT_COUNT;
  logic       FREEZE = 1'b0;
  logic       READ = 1'b0;
  logic       TOKEN, OUT, BUSY;
  logic [7:0] LOST_CNT, READ_ERR_CNT;

  int total = 0;
  int bad   = 0;
  logic [26:0] exp_q[$];
  logic [26:0] fill_words[16];
  logic        armed = 1'b0;
  int          nbits = 0;
  logic [26:0] shreg = '0;

  tjmono_readout_emu #(.ADDR_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .HIT_WR(HIT_WR), .HIT_COL(HIT_COL), .HIT_ROW(HIT_ROW),
    .HIT_LE(HIT_LE), .HIT_TE(HIT_TE), .FULL(FULL), .HIT_COUNT(HIT_COUNT),
    .FREEZE(FREEZE), .READ(READ), .TOKEN(TOKEN), .OUT(OUT), .BUSY(BUSY),
    .LOST_CNT(LOST_CNT), .READ_ERR_CNT(READ_ERR_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  always @(negedge CLK) begin
    if (armed) begin
      if (BUSY !== 1'b1) begin
        nbits = 0;
        total++;
        if (OUT !== 1'b0) begin
          bad++;
          $display("FAIL out_idle got=%b want=0", OUT);
        end
      end else begin
        shreg = {shreg[25:0], OUT};
        nbits++;
        if (nbits == 27) begin
          nbits = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL word_unexpected got=%h want=none", shreg);
          end else begin
            logic [26:0] e;
            e = exp_q.pop_front();
            if (shreg !== e) begin
              bad++;
              $display("FAIL word got=%h want=%h", shreg, e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic logic [26:0] mk(input int col, input int row, input int le, input int te);
    logic [5:0] c;
    logic [8:0] r;
    logic [5:0] l;
    logic [5:0] t;
    c = 6'(col); r = 9'(row); l = 6'(le); t = 6'(te);
    return {c, r, l, t};
  endfunction

  task automatic write_word(input logic [26:0] w);
    {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = w;
    HIT_WR = 1'b1;
    tick();
    HIT_WR = 1'b0;
  endtask

  task automatic pulse_read();
    READ = 1'b1;
    tick();
    READ = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY === 1'b1 && k < 60) begin
      tick();
      k++;
    end
    total++;
    if (k >= 60) begin
      bad++;
      $display("FAIL wait_idle got=busy want=idle");
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    logic [26:0] w1, w2, wx, wy;
    // Reset state
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    armed = 1'b1;
    chk("rst_count", HIT_COUNT, 0);
    chk("rst_full", FULL, 0);
    chk("rst_token", TOKEN, 0);
    chk("rst_out", OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_lost", LOST_CNT, 0);
    chk("rst_err", READ_ERR_CNT, 0);

    // Single hit, hand-computed word
    write_word(mk(5, 300, 10, 20));
    chk("t1_count", HIT_COUNT, 1);
    chk("t1_token", TOKEN, 1);
    exp_q.push_back(27'b000101_100101100_001010_010100);
    pulse_read();
    chk("t1_token_fall", TOKEN, 0);
    chk("t1_busy", BUSY, 1);
    chk("t1_out_msb", OUT, 0);
    chk("t1_count_pop", HIT_COUNT, 0);
    wait_idle();
    chk("t1_busy_end", BUSY, 0);

    // Fill to full (write pointer wraps), overflow by 3
    for (int i = 0; i < 16; i++) begin
      fill_words[i] = mk(i + 1, 100 + 7 * i, i, 63 - i);
      write_word(fill_words[i]);
    end
    chk("t2_full", FULL, 1);
    for (int i = 0; i < 3; i++) write_word(mk(63, 511, 63, 63));
    chk("t2_lost", LOST_CNT, 3);
    chk("t2_count", HIT_COUNT, 16);
    chk("t2_full2", FULL, 1);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(fill_words[i]);
      pulse_read();
      wait_idle();
    end
    chk("t2_token_empty", TOKEN, 0);
    chk("t2_count_empty", HIT_COUNT, 0);
    chk("t2_err", READ_ERR_CNT, 0);

    // Refill and reread; second read lands at n+27 (back to back)
    write_word(mk(33, 1, 2, 3));
    write_word(mk(34, 257, 4, 5));
    write_word(mk(35, 510, 62, 1));
    exp_q.push_back(mk(33, 1, 2, 3));
    pulse_read();
    repeat (26) tick();
    exp_q.push_back(mk(34, 257, 4, 5));
    pulse_read();
    chk("t3_b2b_busy", BUSY, 1);
    chk("t3_b2b_count", HIT_COUNT, 1);
    chk("t3_b2b_err", READ_ERR_CNT, 0);
    wait_idle();
    exp_q.push_back(mk(35, 510, 62, 1));
    pulse_read();
    wait_idle();
    chk("t3_token", TOKEN, 0);

    // Freeze with 2 queued, 4 more written while frozen
    do_reset();
    write_word(mk(1, 11, 1, 1));
    write_word(mk(2, 22, 2, 2));
    FREEZE = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) write_word(mk(40 + i, 400 + i, i, i));
    chk("t4_count6", HIT_COUNT, 6);
    chk("t4_token_frz", TOKEN, 1);
    exp_q.push_back(mk(1, 11, 1, 1));
    pulse_read();
    wait_idle();
    exp_q.push_back(mk(2, 22, 2, 2));
    pulse_read();
    wait_idle();
    chk("t4_token_drained", TOKEN, 0);
    pulse_read();
    chk("t4_err", READ_ERR_CNT, 1);
    chk("t4_nopop", HIT_COUNT, 4);
    chk("t4_nobusy", BUSY, 0);
    FREEZE = 1'b0;
    tick();
    chk("t4_token_rel", TOKEN, 1);
    chk("t4_count_rel", HIT_COUNT, 4);

    // Second READ edge mid-word is ignored
    do_reset();
    w1 = mk(17, 341, 21, 42);
    w2 = mk(46, 170, 42, 21);
    write_word(w1);
    write_word(w2);
    exp_q.push_back(w1);
    pulse_read();
    repeat (8) tick();
    pulse_read();
    chk("t5_err", READ_ERR_CNT, 1);
    chk("t5_busy", BUSY, 1);
    chk("t5_count", HIT_COUNT, 1);
    wait_idle();

    // READ held high: one word only
    write_word(mk(9, 99, 9, 9));
    exp_q.push_back(w2);
    READ = 1'b1;
    repeat (40) tick();
    READ = 1'b0;
    tick();
    chk("t6_count", HIT_COUNT, 1);
    chk("t6_busy", BUSY, 0);
    chk("t6_err", READ_ERR_CNT, 1);

    // Reset mid-word: partial word lost
    pulse_read();
    repeat (11) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t7_out", OUT, 0);
    chk("t7_busy", BUSY, 0);
    chk("t7_count", HIT_COUNT, 0);
    chk("t7_lost", LOST_CNT, 0);
    chk("t7_err", READ_ERR_CNT, 0);
    chk("t7_token", TOKEN, 0);

    // Write and accepted read on the same edge
    wx = mk(60, 5, 0, 31);
    wy = mk(3, 480, 55, 6);
    write_word(wx);
    exp_q.push_back(wx);
    {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = wy;
    HIT_WR = 1'b1;
    READ = 1'b1;
    tick();
    HIT_WR = 1'b0;
    READ = 1'b0;
    chk("t8_count", HIT_COUNT, 1);
    chk("t8_token", TOKEN, 1);
    chk("t8_busy", BUSY, 1);
    wait_idle();
    exp_q.push_back(wy);
    pulse_read();
    wait_idle();
    chk("t8_token_end", TOKEN, 0);

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
